cacheline_adaptor_p: RTL and testbench

//  Memory-side responder for the pipelined cache's line-miss interface. It accepts

---
 rtl/cache_pkg.sv | 10 +
 rtl/cacheline_beat_buf.sv | 29 ++
 rtl/cacheline_adaptor_p.sv | 92 +++++++++
 tb/tb_cacheline_adaptor_p.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: shared widths and FSM state type for the cache line adaptor
package cache_pkg;
  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int ADDR_W  = 32;
  localparam int BEATS   = LINE_W / BURST_W;
  localparam int OFFS    = $clog2(LINE_W / 8);
  localparam int CNT_W   = $clog2(BEATS);
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} adaptor_state_t;
endpackage

// File: rtl/cacheline_beat_buf.sv
// cacheline_beat_buf: line register with whole-line load, beat write and beat read mux
module cacheline_beat_buf
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [LINE_W-1:0]  line_i,
  input  logic               wr_i,
  input  logic [CNT_W-1:0]   idx_i,
  input  logic [BURST_W-1:0] beat_i,
  output logic [LINE_W-1:0]  line_o,
  output logic [BURST_W-1:0] beat_o
);
  logic [LINE_W-1:0] data_q, data_d;
  // whole-line load takes priority over a single beat write
  always_comb begin
    data_d = data_q;
    if (load_i) data_d = line_i;
    else if (wr_i) data_d[idx_i*BURST_W +: BURST_W] = beat_i;
  end
  // line storage, cleared by the active-low async reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) data_q <= '0;
    else data_q <= data_d;
  end
  assign line_o = data_q;
  assign beat_o = data_q[idx_i*BURST_W +: BURST_W];
endmodule

// File: rtl/cacheline_adaptor_p.sv
// cacheline_adaptor_p: line request to 4-beat memory burst adaptor (optional err_o via CACHELINE_ADAPTOR_ERR_EN)
module cacheline_adaptor_p
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic               read_i,
  input  logic               write_i,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  output logic               resp_o,
`ifdef CACHELINE_ADAPTOR_ERR_EN
  output logic               err_o,
`endif
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  output logic [BURST_W-1:0] burst_o,
  input  logic [BURST_W-1:0] burst_i,
  input  logic               resp_i
);
  adaptor_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [LINE_W-1:0] buf_line;
  logic [BURST_W-1:0] buf_beat;
  logic last;
  assign last = resp_i && (cnt_q == CNT_W'(BEATS - 1));
  // write-back data is loaded at accept; fill beats land at the current count
  cacheline_beat_buf u_buf (
    .clk    (clk),
    .rst    (rst),
    .load_i (state_q == IDLE && write_i),
    .line_i (line_i),
    .wr_i   (state_q == RD && resp_i),
    .idx_i  (cnt_q),
    .beat_i (burst_i),
    .line_o (buf_line),
    .beat_o (buf_beat)
  );
  // next state, beat count, latched address and fill line (line_o only moves on the last read beat)
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    line_d = line_q;
    unique case (state_q)
      IDLE: if (write_i || read_i) begin
        state_d = write_i ? WR : RD;
        addr_d = address_i & ~ADDR_W'((1 << OFFS) - 1);
      end
      RD, WR: begin
        cnt_d = resp_i ? cnt_q + 1'b1 : cnt_q;
        state_d = last ? DONE : state_q;
        line_d = (state_q == RD && last) ? {burst_i, buf_line[LINE_W-BURST_W-1:0]} : line_q;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state registers with active-low async reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      line_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      line_q <= line_d;
    end
  end
  assign read_o = state_q == RD;
  assign write_o = state_q == WR;
  assign resp_o = state_q == DONE;
  assign burst_o = (state_q == WR) ? buf_beat : '0;
  assign address_o = addr_q;
  assign line_o = line_q;
`ifdef CACHELINE_ADAPTOR_ERR_EN
  logic err_q;
  // sticky flag for stray beats outside a burst or a conflicting request in IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else err_q <= err_q | (resp_i && (state_q == IDLE || state_q == DONE)) | (state_q == IDLE && read_i && write_i);
  end
  assign err_o = err_q;
`endif
endmodule

// File: tb/tb_cacheline_adaptor_p.sv
// tb_cacheline_adaptor_p: directed self-checking bench for cacheline_adaptor_p
module tb_cacheline_adaptor_p;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] address_i;
  logic read_i, write_i, resp_i;
  logic [255:0] line_i, line_o;
  logic [63:0] burst_i, burst_o;
  logic resp_o, read_o, write_o;
  logic [31:0] address_o;
`ifdef CACHELINE_ADAPTOR_ERR_EN
  logic err_o;
`endif
  int total = 0;
  int bad = 0;
  cacheline_adaptor_p dut (
    .clk       (clk),
    .rst       (rst),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .line_i    (line_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
`ifdef CACHELINE_ADAPTOR_ERR_EN
    .err_o     (err_o),
`endif
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .burst_o   (burst_o),
    .burst_i   (burst_i),
    .resp_i    (resp_i)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic [63:0] d);
    resp_i = 1'b1;
    burst_i = d;
    step();
  endtask
  task automatic test_reset();
    rst = 1'b0; address_i = '0; read_i = 0; write_i = 0; resp_i = 0; line_i = '0; burst_i = '0;
    #1;
    total++; if (resp_o !== 1'b0) begin bad++; $display("FAIL reset_resp got=%b exp=0", resp_o); end
    total++; if ({read_o, write_o} !== 2'b00) begin bad++; $display("FAIL reset_rdwr got=%b exp=00", {read_o, write_o}); end
    total++; if (address_o !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", address_o); end
    total++; if (burst_o !== 64'h0) begin bad++; $display("FAIL reset_burst got=%h exp=0", burst_o); end
    total++; if (line_o !== 256'h0) begin bad++; $display("FAIL reset_line got=%h exp=0", line_o); end
`ifdef CACHELINE_ADAPTOR_ERR_EN
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_o); end
`endif
    step(); step();
    rst = 1'b1;
    step();
  endtask
  task automatic test_read();
    address_i = 32'h0000_1234; read_i = 1'b1;
    step();
    total++; if (read_o !== 1'b1) begin bad++; $display("FAIL rd_read_o got=%b exp=1", read_o); end
    total++; if (address_o !== 32'h0000_1220) begin bad++; $display("FAIL rd_addr got=%h exp=00001220", address_o); end
    beat(64'hA0); beat(64'hA1); beat(64'hA2);
    total++; if (resp_o !== 1'b0) begin bad++; $display("FAIL rd_early_resp got=%b exp=0", resp_o); end
    beat(64'hA3);
    resp_i = 1'b0;
    total++; if ({resp_o, read_o} !== 2'b10) begin bad++; $display("FAIL rd_done got=%b exp=10", {resp_o, read_o}); end
    total++; if (line_o !== {64'hA3, 64'hA2, 64'hA1, 64'hA0}) begin bad++; $display("FAIL rd_line got=%h exp=a3a2a1a0", line_o); end
    read_i = 1'b0;
    step();
    total++; if (resp_o !== 1'b0) begin bad++; $display("FAIL rd_resp_pulse got=%b exp=0", resp_o); end
  endtask
  task automatic test_write_gap();
    line_i = {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002, 64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000};
    address_i = 32'h0000_5678; write_i = 1'b1;
    step();
    total++; if (write_o !== 1'b1) begin bad++; $display("FAIL wr_write_o got=%b exp=1", write_o); end
    total++; if (burst_o !== 64'hD0D0_0000_0000_0000) begin bad++; $display("FAIL wr_beat0 got=%h exp=d0d0000000000000", burst_o); end
    beat(64'h0); beat(64'h0);
    resp_i = 1'b0;
    step(); step();
    total++; if (burst_o !== 64'hD2D2_0000_0000_0002 && burst_o === 64'hD1D1_0000_0000_0001) begin end
    total++; if (burst_o !== 64'hD2D2_0000_0000_0002) begin bad++; $display("FAIL wr_gap_beat got=%h exp=d2d2000000000002", burst_o); end
    total++; if (write_o !== 1'b1) begin bad++; $display("FAIL wr_gap_write_o got=%b exp=1", write_o); end
    beat(64'h0);
    total++; if (burst_o !== 64'hD3D3_0000_0000_0003) begin bad++; $display("FAIL wr_beat3 got=%h exp=d3d3000000000003", burst_o); end
    beat(64'h0);
    resp_i = 1'b0;
    total++; if ({write_o, resp_o} !== 2'b01) begin bad++; $display("FAIL wr_done got=%b exp=01", {write_o, resp_o}); end
    total++; if (line_o !== {64'hA3, 64'hA2, 64'hA1, 64'hA0}) begin bad++; $display("FAIL wr_line_kept got=%h exp=a3a2a1a0", line_o); end
    write_i = 1'b0;
    step();
  endtask
  task automatic test_spurious();
    resp_i = 1'b1;
    step();
    resp_i = 1'b0;
    total++; if ({read_o, write_o, resp_o} !== 3'b000) begin bad++; $display("FAIL spur_state got=%b exp=000", {read_o, write_o, resp_o}); end
    step();
    total++; if ({read_o, write_o, resp_o} !== 3'b000) begin bad++; $display("FAIL spur_after got=%b exp=000", {read_o, write_o, resp_o}); end
`ifdef CACHELINE_ADAPTOR_ERR_EN
    total++; if (err_o !== 1'b1) begin bad++; $display("FAIL spur_err got=%b exp=1", err_o); end
`endif
  endtask
  task automatic test_both();
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    line_i = {64'h33, 64'h22, 64'h11, 64'h00};
    address_i = 32'h0000_0100; read_i = 1'b1; write_i = 1'b1;
    step();
    total++; if ({write_o, read_o} !== 2'b10) begin bad++; $display("FAIL both_wr got=%b exp=10", {write_o, read_o}); end
`ifdef CACHELINE_ADAPTOR_ERR_EN
    total++; if (err_o !== 1'b1) begin bad++; $display("FAIL both_err got=%b exp=1", err_o); end
`endif
    beat(64'h0); beat(64'h0); beat(64'h0);
    total++; if (burst_o !== 64'h33) begin bad++; $display("FAIL both_beat3 got=%h exp=33", burst_o); end
    beat(64'h0);
    resp_i = 1'b0;
    total++; if (resp_o !== 1'b1) begin bad++; $display("FAIL both_resp got=%b exp=1", resp_o); end
    read_i = 1'b0; write_i = 1'b0;
    step();
  endtask
  task automatic test_mid_reset();
    address_i = 32'h0000_0040; read_i = 1'b1;
    step();
    beat(64'hB0); beat(64'hB1);
    resp_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    total++; if ({read_o, write_o, resp_o} !== 3'b000) begin bad++; $display("FAIL mrst_ctl got=%b exp=000", {read_o, write_o, resp_o}); end
    total++; if (address_o !== 32'h0) begin bad++; $display("FAIL mrst_addr got=%h exp=0", address_o); end
    total++; if (line_o !== 256'h0) begin bad++; $display("FAIL mrst_line got=%h exp=0", line_o); end
    total++; if (burst_o !== 64'h0) begin bad++; $display("FAIL mrst_burst got=%h exp=0", burst_o); end
    read_i = 1'b0;
    step();
    rst = 1'b1;
    step();
    address_i = 32'h0000_009F; read_i = 1'b1;
    step();
    total++; if (address_o !== 32'h0000_0080) begin bad++; $display("FAIL mrst_addr2 got=%h exp=00000080", address_o); end
    beat(64'hC0); beat(64'hC1); beat(64'hC2); beat(64'hC3);
    resp_i = 1'b0;
    total++; if (resp_o !== 1'b1) begin bad++; $display("FAIL mrst_resp got=%b exp=1", resp_o); end
    total++; if (line_o !== {64'hC3, 64'hC2, 64'hC1, 64'hC0}) begin bad++; $display("FAIL mrst_line2 got=%h exp=c3c2c1c0", line_o); end
    read_i = 1'b0;
    step();
  endtask
  task automatic test_back_to_back();
    line_i = {64'hE3, 64'hE2, 64'hE1, 64'hE0};
    address_i = 32'h0000_0200; write_i = 1'b1;
    step();
    total++; if (burst_o !== 64'hE0) begin bad++; $display("FAIL b2b_wbeat0 got=%h exp=e0", burst_o); end
    beat(64'h0); beat(64'h0); beat(64'h0); beat(64'h0);
    resp_i = 1'b0;
    total++; if (resp_o !== 1'b1) begin bad++; $display("FAIL b2b_wresp got=%b exp=1", resp_o); end
    total++; if (line_o !== {64'hC3, 64'hC2, 64'hC1, 64'hC0}) begin bad++; $display("FAIL b2b_wline got=%h exp=c3c2c1c0", line_o); end
    write_i = 1'b0;
    step();
    address_i = 32'h0000_0300; read_i = 1'b1;
    step();
    total++; if ({read_o, write_o} !== 2'b10) begin bad++; $display("FAIL b2b_rd got=%b exp=10", {read_o, write_o}); end
    total++; if (address_o !== 32'h0000_0300) begin bad++; $display("FAIL b2b_addr got=%h exp=00000300", address_o); end
    beat(64'hF0); beat(64'hF1); beat(64'hF2); beat(64'hF3);
    resp_i = 1'b0;
    total++; if (resp_o !== 1'b1) begin bad++; $display("FAIL b2b_rresp got=%b exp=1", resp_o); end
    total++; if (line_o !== {64'hF3, 64'hF2, 64'hF1, 64'hF0}) begin bad++; $display("FAIL b2b_rline got=%h exp=f3f2f1f0", line_o); end
    read_i = 1'b0;
    step();
    total++; if ({read_o, write_o, resp_o} !== 3'b000) begin bad++; $display("FAIL b2b_idle got=%b exp=000", {read_o, write_o, resp_o}); end
  endtask
  initial begin
    test_reset();
    test_read();
    test_write_gap();
    test_spurious();
    test_both();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
